// File: rtl/pio_pkg.sv
// Shared definitions for the PIO family: register offsets and edge-select codes.
package pio_pkg;

   localparam int unsigned PIO_AW = 3;

   localparam logic [PIO_AW-1:0] PIO_DATA    = 3'd0;
   localparam logic [PIO_AW-1:0] PIO_DIR     = 3'd1;
   localparam logic [PIO_AW-1:0] PIO_IRQMASK = 3'd2;
   localparam logic [PIO_AW-1:0] PIO_EDGECAP = 3'd3;
   localparam logic [PIO_AW-1:0] PIO_OUTSET  = 3'd4;
   localparam logic [PIO_AW-1:0] PIO_OUTCLR  = 3'd5;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync.sv
// Multi-flop input synchroniser, cleared by synchronous reset.
module pio_sync #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   // Shift the asynchronous pins through the flop chain
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pio_gpio_avalon.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, edge capture, maskable irq.
module pio_gpio_avalon
   import pio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
   parameter int unsigned      SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PIO_AW-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  pio_in,
   output logic [WIDTH-1:0]  pio_out,
   output logic [WIDTH-1:0]  pio_oe,
   output logic              irq
);

   // Detection stays off until the synchroniser and prev hold real pin data
   localparam int unsigned PRIME = SYNC_STAGES + 1;
   localparam int unsigned CW    = $clog2(PRIME + 1);
   // Any value other than rise/fall selects both edges
   localparam logic USE_RISE = (EDGE_TYPE != EDGE_FALL);
   localparam logic USE_FALL = (EDGE_TYPE != EDGE_RISE);

   logic [WIDTH-1:0] out_q, dir_q, mask_q, cap_q, prev_q;
   logic [WIDTH-1:0] in_sync, wd, rise, fall, det, cap_clr;
   logic [CW-1:0]    prime_q;
   logic             wr_en;
   logic             unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pio_in),
      .q     (in_sync)
   );

   // Edge detection gated by the prime counter, plus the write-1-to-clear mask
   always_comb begin
      rise    = in_sync & ~prev_q;
      fall    = ~in_sync & prev_q;
      det     = '0;
      cap_clr = '0;
      if (prime_q == CW'(PRIME)) begin
         det = ({WIDTH{USE_RISE}} & rise) | ({WIDTH{USE_FALL}} & fall);
      end
      if (wr_en && (address == PIO_EDGECAP)) begin
         cap_clr = wd;
      end
   end

   // Register file, edge history and prime counter
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= RESET_OUT;
         dir_q   <= RESET_DIR;
         mask_q  <= '0;
         cap_q   <= '0;
         prev_q  <= '0;
         prime_q <= '0;
      end else begin
         prev_q <= in_sync;
         if (prime_q != CW'(PRIME)) begin
            prime_q <= prime_q + CW'(1);
         end
         // A new edge wins over a simultaneous clear of the same bit
         cap_q <= (cap_q & ~cap_clr) | det;
         if (wr_en) begin
            case (address)
               PIO_DATA:    out_q  <= wd;
               PIO_DIR:     dir_q  <= wd;
               PIO_IRQMASK: mask_q <= wd;
               PIO_OUTSET:  out_q  <= out_q | wd;
               PIO_OUTCLR:  out_q  <= out_q & ~wd;
               default:     ;
            endcase
         end
      end
   end

   // Zero-latency read mux; unimplemented bits and offsets read 0
   always_comb begin
      readdata = '0;
      case (address)
         PIO_DATA:    readdata = 32'((dir_q & out_q) | (~dir_q & in_sync));
         PIO_DIR:     readdata = 32'(dir_q);
         PIO_IRQMASK: readdata = 32'(mask_q);
         PIO_EDGECAP: readdata = 32'(cap_q);
         default:     readdata = '0;
      endcase
   end

   assign pio_out = out_q;
   assign pio_oe  = dir_q;
   assign irq     = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_avalon.sv
// Self-checking bench for pio_gpio_avalon: directed scenarios plus randomized traffic vs a reference model.
module tb_pio_gpio_avalon;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic        cs0, cs1, cs2;
   logic [31:0] readdata0, readdata1, readdata2;
   logic [7:0]  pio_in0, pio_out0, pio_oe0;
   logic [7:0]  pio_in1, pio_out1, pio_oe1;
   logic [0:0]  pio_in2, pio_out2, pio_oe2;
   logic        irq0, irq1, irq2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   pio_gpio_avalon #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs0), .write_n(write_n),
      .writedata(writedata), .readdata(readdata0), .pio_in(pio_in0), .pio_out(pio_out0),
      .pio_oe(pio_oe0), .irq(irq0));

   pio_gpio_avalon #(.WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
      .writedata(writedata), .readdata(readdata1), .pio_in(pio_in1), .pio_out(pio_out1),
      .pio_oe(pio_oe1), .irq(irq1));

   pio_gpio_avalon #(.WIDTH(1), .RESET_OUT(1'b0), .RESET_DIR(1'b1), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs2), .write_n(write_n),
      .writedata(writedata), .readdata(readdata2), .pio_in(pio_in2), .pio_out(pio_out2),
      .pio_oe(pio_oe2), .irq(irq2));

   // Reference model of dut0: pin history, register contents and edges seen since reset
   logic [7:0] m_out, m_dir, m_mask, m_cap;
   logic [7:0] m_hist [0:S];
   logic [7:0] m_now, m_before, m_hit, m_clr, m_wd;
   int         m_since;

   always @(posedge clk) begin
      if (reset) begin
         m_out   = 8'hA5;
         m_dir   = 8'hFF;
         m_mask  = 8'h00;
         m_cap   = 8'h00;
         m_since = 0;
         for (int i = 0; i <= int'(S); i++) m_hist[i] = 8'h00;
      end else begin
         // Pin value as seen now, and one cycle earlier, after synchronisation
         m_now    = m_hist[S-1];
         m_before = m_hist[S];
         m_hit    = (m_since >= int'(S) + 1) ? (m_now & ~m_before) : 8'h00;
         m_clr    = 8'h00;
         m_wd     = writedata[7:0];
         if (cs0 && !write_n) begin
            case (address)
               3'd0: m_out  = m_wd;
               3'd1: m_dir  = m_wd;
               3'd2: m_mask = m_wd;
               3'd3: m_clr  = m_wd;
               3'd4: m_out  = m_out | m_wd;
               3'd5: m_out  = m_out & ~m_wd;
               default: ;
            endcase
         end
         m_cap = (m_cap & ~m_clr) | m_hit;
         for (int i = int'(S); i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = pio_in0;
         if (m_since < 1000) m_since++;
      end
   end

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {24'h0, (m_dir & m_out) | (~m_dir & m_hist[S-1])};
         3'd1:    return {24'h0, m_dir};
         3'd2:    return {24'h0, m_mask};
         3'd3:    return {24'h0, m_cap};
         default: return 32'h0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic read_chk(input string tag, input int which, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      address = a;
      #1;
      rd = (which == 0) ? readdata0 : (which == 1) ? readdata1 : readdata2;
      check(tag, rd, exp);
   endtask

   task automatic bus_write(input int which, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cs0 = (which == 0); cs1 = (which == 1); cs2 = (which == 2);
      write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      reset = 1'b1; cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
      address = 3'd0; writedata = 32'h0;
      pio_in0 = 8'h00; pio_in1 = 8'hFF; pio_in2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset values
      check("rst_out", {24'h0, pio_out0}, 32'hA5);
      check("rst_oe", {24'h0, pio_oe0}, 32'hFF);
      check("rst_irq", {31'h0, irq0}, 32'h0);
      read_chk("rst_data", 0, 3'd0, 32'hA5);
      read_chk("rst_mask", 0, 3'd2, 32'h0);
      read_chk("rst_cap", 0, 3'd3, 32'h0);

      // Direction, data, atomic set/clear and mixed DATA read
      bus_write(0, 3'd1, 32'h0F);
      bus_write(0, 3'd0, 32'h3C);
      bus_write(0, 3'd4, 32'h80);
      bus_write(0, 3'd5, 32'h04);
      check("setclr_out", {24'h0, pio_out0}, 32'hB8);
      check("setclr_oe", {24'h0, pio_oe0}, 32'h0F);
      read_chk("mixed_data", 0, 3'd0, 32'h08);
      read_chk("outset_rd", 0, 3'd4, 32'h0);

      // Rising edge latency and irq clear
      bus_write(0, 3'd1, 32'h00);
      bus_write(0, 3'd2, 32'h08);
      pio_in0 = 8'h08;
      @(negedge clk);
      @(negedge clk);
      read_chk("cap_early", 0, 3'd3, 32'h0);
      check("irq_early", {31'h0, irq0}, 32'h0);
      @(negedge clk);
      read_chk("cap_edge3", 0, 3'd3, 32'h08);
      check("irq_edge3", {31'h0, irq0}, 32'h1);
      bus_write(0, 3'd3, 32'h08);
      check("irq_clr", {31'h0, irq0}, 32'h0);
      read_chk("cap_clr", 0, 3'd3, 32'h0);

      // Sticky capture, falling edges ignored, set wins over clear on same bit
      pio_in0 = 8'h0E;
      repeat (4) @(negedge clk);
      read_chk("cap_06", 0, 3'd3, 32'h06);
      check("irq_masked", {31'h0, irq0}, 32'h0);
      pio_in0 = 8'h08;
      repeat (4) @(negedge clk);
      read_chk("cap_nofall", 0, 3'd3, 32'h06);
      pio_in0 = 8'h0C;
      @(negedge clk);
      @(negedge clk);
      cs0 = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h06;
      @(negedge clk);
      cs0 = 1'b0; write_n = 1'b1;
      read_chk("set_wins", 0, 3'd3, 32'h04);

      // Prime suppression on pins held high through reset, then a falling edge
      read_chk("prime_cap", 1, 3'd3, 32'h0);
      pio_in1 = 8'hFE;
      repeat (4) @(negedge clk);
      read_chk("fall_cap", 1, 3'd3, 32'h01);
      check("fall_irq", {31'h0, irq1}, 32'h0);

      // One-bit instance: upper bits ignored, reserved offset, reset mid-burst
      bus_write(2, 3'd0, 32'hFFFF_FFFF);
      read_chk("w1_data", 2, 3'd0, 32'h1);
      bus_write(2, 3'd6, 32'hFFFF_FFFF);
      read_chk("w1_rsvd", 2, 3'd6, 32'h0);
      read_chk("w1_data2", 2, 3'd0, 32'h1);
      pio_in2 = 1'b1;
      repeat (4) @(negedge clk);
      bus_write(2, 3'd2, 32'h1);
      check("w1_irq", {31'h0, irq2}, 32'h1);
      bus_write(2, 3'd1, 32'h0);
      @(negedge clk);
      cs2 = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h0; reset = 1'b1;
      @(negedge clk);
      cs2 = 1'b0; write_n = 1'b1; reset = 1'b0;
      check("w1_rst_out", {31'h0, pio_out2}, 32'h0);
      check("w1_rst_oe", {31'h0, pio_oe2}, 32'h1);
      check("w1_rst_irq", {31'h0, irq2}, 32'h0);
      read_chk("w1_rst_cap", 2, 3'd3, 32'h0);
      repeat (2) @(negedge clk);
      cs2 = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h1;
      @(negedge clk);
      cs2 = 1'b0; write_n = 1'b1;
      repeat (4) @(negedge clk);
      read_chk("w1_prime", 2, 3'd3, 32'h0);

      // Randomized traffic on dut0 against the reference model
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         check("rnd_out", {24'h0, pio_out0}, {24'h0, m_out});
         check("rnd_oe", {24'h0, pio_oe0}, {24'h0, m_dir});
         check("rnd_irq", {31'h0, irq0}, {31'h0, |(m_cap & m_mask)});
         begin
            logic [2:0] ra;
            ra = 3'($urandom_range(0, 7));
            read_chk("rnd_rd", 0, ra, m_read(ra));
         end
         if ($urandom_range(0, 3) == 0) pio_in0 = 8'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            cs0 = 1'b1; write_n = 1'b0;
            address = 3'($urandom_range(0, 7));
            writedata = $urandom;
         end else begin
            cs0 = 1'b0; write_n = 1'b1;
         end
         reset = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      cs0 = 1'b0; write_n = 1'b1; reset = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
